// File: rtl/apb_mem_pkg.sv
// Shared definitions for the apb_memory requester: FSM encoding and default geometry.
package apb_mem_pkg;

   localparam int unsigned DefAddrWidth = 7;
   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefTimeout   = 16;

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StSetup,
      StAccess,
      StResp
   } state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Clearable 8-bit up-counter; tc_o is a registered flag raised the cycle after the
// count reaches TIMEOUT-1, so an access gives up after TIMEOUT+1 ACCESS cycles.
module apb_timeout_cnt #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [7:0] cnt_q, cnt_d;
   logic       tc_q, tc_d;

   always_comb begin
      cnt_d = cnt_q;
      tc_d  = tc_q;
      if (clr_i) begin
         cnt_d = '0;
         tc_d  = 1'b0;
      end else if (en_i) begin
         cnt_d = cnt_q + 8'd1;
         tc_d  = (cnt_q == 8'(TIMEOUT - 1));
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign tc_o = tc_q;

endmodule

// File: rtl/apb_mem_requester.sv
// Requester stage for apb_memory: turns valid/ready commands into SETUP/ACCESS transfers,
// issues the post-reset memory clear and converts stalled accesses into error responses.
module apb_mem_requester
   import apb_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned TIMEOUT    = DefTimeout
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_wr_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  mem_sel_o,
   output logic                  mem_rst_o,
   output logic                  mem_valid_o,
   output logic                  mem_wr_rd_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ready_i
);

   state_e                state_q, state_d;
   logic                  init_done_q, init_done_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  mem_sel_q, mem_sel_d;
   logic                  mem_rst_q, mem_rst_d;
   logic                  mem_valid_q, mem_valid_d;
   logic                  mem_wr_rd_q, mem_wr_rd_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  cnt_clr, cnt_en, cnt_tc;

   apb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (cnt_tc)
   );

   // Output registers are loaded with the values belonging to the state being entered.
   always_comb begin
      state_d     = state_q;
      init_done_d = init_done_q;
      cmd_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      mem_sel_d   = 1'b0;
      mem_rst_d   = 1'b0;
      mem_valid_d = 1'b0;
      mem_wr_rd_d = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;

      unique case (state_q)
         StInit: begin
            // First edge after reset drives the clear, the second moves on to IDLE.
            if (!init_done_q) begin
               init_done_d = 1'b1;
               mem_sel_d   = 1'b1;
               mem_rst_d   = 1'b1;
            end else begin
               state_d     = StIdle;
               cmd_ready_d = 1'b1;
            end
         end
         StIdle: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid_i && cmd_ready_q) begin
               state_d     = StSetup;
               cmd_ready_d = 1'b0;
               mem_sel_d   = 1'b1;
               mem_wr_rd_d = cmd_wr_i;
               mem_addr_d  = cmd_addr_i;
               mem_wdata_d = cmd_wdata_i;
            end
         end
         StSetup: begin
            state_d     = StAccess;
            cnt_clr     = 1'b1;
            mem_sel_d   = 1'b1;
            mem_valid_d = 1'b1;
            mem_wr_rd_d = mem_wr_rd_q;
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
         end
         StAccess: begin
            cnt_en = 1'b1;
            if (mem_ready_i) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = mem_wr_rd_q ? '0 : mem_rdata_i;
            end else if (cnt_tc) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               mem_sel_d   = 1'b1;
               mem_valid_d = 1'b1;
               mem_wr_rd_d = mem_wr_rd_q;
               mem_addr_d  = mem_addr_q;
               mem_wdata_d = mem_wdata_q;
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               state_d     = StIdle;
               cmd_ready_d = 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rsp_rdata_q;
               rsp_err_d   = rsp_err_q;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= StInit;
         init_done_q <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_sel_q   <= 1'b0;
         mem_rst_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_wr_rd_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         init_done_q <= init_done_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_sel_q   <= mem_sel_d;
         mem_rst_q   <= mem_rst_d;
         mem_valid_q <= mem_valid_d;
         mem_wr_rd_q <= mem_wr_rd_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign mem_sel_o   = mem_sel_q;
   assign mem_rst_o   = mem_rst_q;
   assign mem_valid_o = mem_valid_q;
   assign mem_wr_rd_o = mem_wr_rd_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule
